apb_spi_master: RTL

- Parametrised APB-slave SPI master; next generation of the fixed 16-bit APB-SPI bridge.
- Adds configurable word width, multiple chip selects, CPOL/CPHA modes, MSB/LSB-first order, and a programmable clock divider.
- Adds RX-valid and overrun status and error signalling on APB.
- Sits on the APB peripheral bus behind the AXI-APB bridge.

---
 rtl/apb_spi_pkg.sv | 29 ++
 rtl/spi_master_core.sv | 121 ++++++++++++
 rtl/apb_spi_master.sv | 138 +++++++++++++
 3 files changed

// File: rtl/apb_spi_pkg.sv
// Shared definitions for the APB SPI master: register offsets, bit positions,
// transfer configuration and the core FSM state encoding.
package apb_spi_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_CLKDIV = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_RXV     = 1;
    localparam int ST_OVR     = 2;

    localparam int CTRL_CPOL  = 0;
    localparam int CTRL_CPHA  = 1;
    localparam int CTRL_LSB   = 2;
    localparam int CTRL_CS_LO = 4;
    localparam int CTRL_IEN   = 7;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_t;

    typedef struct packed {
        logic [2:0] cs_sel;
        logic       lsb_first;
        logic       cpha;
        logic       cpol;
    } spi_cfg_t;

endpackage

// File: rtl/spi_master_core.sv
// SPI shift engine: half-period divider, edge counter, TX/RX shift registers
// and the IDLE/SETUP/XFER/HOLD sequencer. Config is latched on start.
module spi_master_core
    import apb_spi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              start,
    input  logic [DATA_W-1:0] word,
    input  spi_cfg_t          cfg,
    input  logic [DIV_W-1:0]  div,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_word,
    output logic [NUM_CS-1:0] spi_cs_l,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    spi_state_t        state;
    spi_cfg_t          cfg_r;
    logic [DIV_W-1:0]  div_r, div_cnt;
    logic [EW-1:0]     edge_cnt;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic [NUM_CS-1:0] cs_dec;
    logic              tick;

    function automatic logic head(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    // An out-of-range cs_sel matches no line, so the word goes out unselected.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++)
            cs_dec[i] = (cfg.cs_sel != 3'(i));
    end

    assign tick    = (div_cnt == div_r);
    assign busy    = (state != IDLE);
    assign done    = (state == HOLD) && tick;
    assign rx_word = rx_sr;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            cfg_r    <= '0;
            div_r    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            spi_cs_l <= '1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    spi_clk <= cfg.cpol;
                    if (start) begin
                        state    <= SETUP;
                        cfg_r    <= cfg;
                        div_r    <= div;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        spi_cs_l <= cs_dec;
                        // cpha=0 needs the first bit on the wire before the first edge
                        if (!cfg.cpha) begin
                            spi_mosi <= head(word, cfg.lsb_first);
                            tx_sr    <= adv(word, cfg.lsb_first);
                        end else begin
                            tx_sr    <= word;
                        end
                    end
                end
                SETUP: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) state <= XFER;
                end
                XFER: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        spi_clk  <= ~spi_clk;
                        edge_cnt <= edge_cnt + 1'b1;
                        // even edges are leading; cpha picks which kind samples
                        if (edge_cnt[0] == cfg_r.cpha) begin
                            rx_sr <= cfg_r.lsb_first ? {spi_miso, rx_sr[DATA_W-1:1]}
                                                     : {rx_sr[DATA_W-2:0], spi_miso};
                        end else begin
                            spi_mosi <= head(tx_sr, cfg_r.lsb_first);
                            tx_sr    <= adv(tx_sr, cfg_r.lsb_first);
                        end
                        if (edge_cnt == LAST_EDGE) state <= HOLD;
                    end
                end
                HOLD: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        state    <= IDLE;
                        spi_cs_l <= '1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/apb_spi_master.sv
// APB slave front end for the SPI master: register decode, status flags and
// error response. Define SPI_IRQ_EN to add the irq output and CTRL.ien bit.
module apb_spi_master
    import apb_spi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [31:0]       PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CS-1:0] spi_cs_l,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
`ifdef SPI_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic [1:0]        reg_sel;
    logic              mapped, access, wr_ok, rd_ok, start, rd_clr;
    logic              busy, done, rv_keep, ov_keep;
    logic [DATA_W-1:0] rx_word, rxdata;
    logic              rx_valid, overrun;
    spi_cfg_t          cfg_q;
    logic [DIV_W-1:0]  div_q;
    logic              unused_bits;

    assign reg_sel     = PADDR[3:2];
    assign mapped      = (PADDR[31:4] == '0);
    assign access      = PSEL & PENABLE;
    assign PREADY      = 1'b1;
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    // STATUS is read-only, so writing it while busy is harmless and not an error.
    assign PSLVERR = access & (!mapped | (PWRITE & busy & (reg_sel != REG_STATUS)));
    assign wr_ok   = access & PWRITE & !PSLVERR;
    assign rd_ok   = access & !PWRITE & !PSLVERR;
    assign start   = wr_ok & (reg_sel == REG_DATA);
    assign rd_clr  = rd_ok & (reg_sel == REG_DATA);
    assign rv_keep = rx_valid & !rd_clr;
    assign ov_keep = overrun & !rd_clr;

`ifdef SPI_IRQ_EN
    logic ien_q;
    assign irq = rx_valid & ien_q;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rxdata   <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            cfg_q    <= '0;
            div_q    <= '0;
`ifdef SPI_IRQ_EN
            ien_q    <= 1'b0;
`endif
        end else begin
            // a same-cycle RXDATA read clears first, then completion sets
            if (done) begin
                rxdata   <= rx_word;
                rx_valid <= 1'b1;
                overrun  <= ov_keep | rv_keep;
            end else begin
                rx_valid <= rv_keep;
                overrun  <= ov_keep;
            end
            if (wr_ok && reg_sel == REG_CTRL) begin
                cfg_q.cpol      <= PWDATA[CTRL_CPOL];
                cfg_q.cpha      <= PWDATA[CTRL_CPHA];
                cfg_q.lsb_first <= PWDATA[CTRL_LSB];
                cfg_q.cs_sel    <= PWDATA[CTRL_CS_LO +: 3];
`ifdef SPI_IRQ_EN
                ien_q           <= PWDATA[CTRL_IEN];
`endif
            end
            if (wr_ok && reg_sel == REG_CLKDIV)
                div_q <= PWDATA[DIV_W-1:0];
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && mapped) begin
            unique case (reg_sel)
                REG_DATA:   PRDATA[DATA_W-1:0] = rxdata;
                REG_STATUS: begin
                    PRDATA[ST_BUSY] = busy;
                    PRDATA[ST_RXV]  = rx_valid;
                    PRDATA[ST_OVR]  = overrun;
                end
                REG_CTRL: begin
                    PRDATA[CTRL_CPOL]       = cfg_q.cpol;
                    PRDATA[CTRL_CPHA]       = cfg_q.cpha;
                    PRDATA[CTRL_LSB]        = cfg_q.lsb_first;
                    PRDATA[CTRL_CS_LO +: 3] = cfg_q.cs_sel;
`ifdef SPI_IRQ_EN
                    PRDATA[CTRL_IEN]        = ien_q;
`endif
                end
                REG_CLKDIV: PRDATA[DIV_W-1:0] = div_q;
                default:    PRDATA = '0;
            endcase
        end
    end

    spi_master_core #(
        .DATA_W (DATA_W),
        .NUM_CS (NUM_CS),
        .DIV_W  (DIV_W)
    ) u_core (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .start    (start),
        .word     (PWDATA[DATA_W-1:0]),
        .cfg      (cfg_q),
        .div      (div_q),
        .busy     (busy),
        .done     (done),
        .rx_word  (rx_word),
        .spi_cs_l (spi_cs_l),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

endmodule
